// File: rtl/edge_threshold.sv
// Binarises an edge-magnitude pixel stream against an adaptive threshold,
// tracks raster position and per-frame edge counts.
module edge_threshold #(
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int BORDER      = 2,
  parameter int THRESH_INIT = 32,
  parameter int THRESH_MIN  = 4,
  parameter int THRESH_MAX  = 250,
  parameter int STEP        = 2,
  parameter int COUNT_HI    = 2000,
  parameter int COUNT_LO    = 500
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        en,
  input  logic        Sof,
  input  logic [7:0]  PixelIn,
  output logic [7:0]  PixelOut,
  output logic        EdgeFlag,
  output logic [7:0]  Threshold,
  output logic [15:0] EdgeCount,
  output logic        FrameDone
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r;
  logic [8:0]  col_r;
  logic [8:0]  row_r;
  logic [15:0] count_r;

  logic [8:0]  pos_col_s;
  logic [8:0]  pos_row_s;
  logic [8:0]  col_nxt_s;
  logic [8:0]  row_nxt_s;
  logic        active_s;
  logic        edge_s;
  logic        last_s;
  logic [15:0] count_base_s;
  logic [15:0] count_nxt_s;
  logic [8:0]  thr_up_s;
  logic [7:0]  thr_hi_s;
  logic [7:0]  thr_lo_s;
  logic [7:0]  thr_adj_s;

  // Pixel classification, raster advance and end-of-frame threshold decision
  always_comb begin
    pos_col_s    = Sof ? 9'd0 : col_r;
    pos_row_s    = Sof ? 9'd0 : row_r;
    active_s     = Sof || (state_r == RUN);
    edge_s       = active_s && (PixelIn >= Threshold) &&
                   (pos_col_s >= 9'(BORDER)) && (pos_row_s >= 9'(BORDER));
    // Sof at the last-pixel position restarts the frame instead of ending it
    last_s       = !Sof && (state_r == RUN) &&
                   (col_r == 9'(WIDTH - 1)) && (row_r == 9'(HEIGHT - 1));

    if (pos_col_s == 9'(WIDTH - 1)) begin
      col_nxt_s = 9'd0;
      if (pos_row_s == 9'(HEIGHT - 1)) begin
        row_nxt_s = 9'd0;
      end else begin
        row_nxt_s = pos_row_s + 9'd1;
      end
    end else begin
      col_nxt_s = pos_col_s + 9'd1;
      row_nxt_s = pos_row_s;
    end

    count_base_s = Sof ? 16'd0 : count_r;
    if (edge_s && (count_base_s != 16'hFFFF)) begin
      count_nxt_s = count_base_s + 16'd1;
    end else begin
      count_nxt_s = count_base_s;
    end

    thr_up_s = {1'b0, Threshold} + 9'(STEP);
    if (thr_up_s > 9'(THRESH_MAX)) begin
      thr_hi_s = 8'(THRESH_MAX);
    end else begin
      thr_hi_s = thr_up_s[7:0];
    end

    if ({1'b0, Threshold} < (9'(THRESH_MIN) + 9'(STEP))) begin
      thr_lo_s = 8'(THRESH_MIN);
    end else begin
      thr_lo_s = Threshold - 8'(STEP);
    end

    if (count_nxt_s > 16'(COUNT_HI)) begin
      thr_adj_s = thr_hi_s;
    end else if (count_nxt_s < 16'(COUNT_LO)) begin
      thr_adj_s = thr_lo_s;
    end else begin
      thr_adj_s = Threshold;
    end
  end

  // Frame FSM, raster counters, statistics and registered pixel output
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      col_r     <= 9'd0;
      row_r     <= 9'd0;
      count_r   <= 16'd0;
      PixelOut  <= 8'h00;
      EdgeFlag  <= 1'b0;
      EdgeCount <= 16'd0;
      FrameDone <= 1'b0;
      Threshold <= 8'(THRESH_INIT);
    end else begin
      FrameDone <= 1'b0;
      if (en) begin
        PixelOut <= edge_s ? 8'hFF : 8'h00;
        EdgeFlag <= edge_s;
        if (Sof) begin
          state_r <= RUN;
          col_r   <= col_nxt_s;
          row_r   <= row_nxt_s;
          count_r <= count_nxt_s;
        end else begin
          case (state_r)
            RUN: begin
              if (last_s) begin
                state_r   <= IDLE;
                col_r     <= 9'd0;
                row_r     <= 9'd0;
                count_r   <= 16'd0;
                EdgeCount <= count_nxt_s;
                FrameDone <= 1'b1;
                Threshold <= thr_adj_s;
              end else begin
                col_r   <= col_nxt_s;
                row_r   <= row_nxt_s;
                count_r <= count_nxt_s;
              end
            end
            IDLE: begin
              state_r <= IDLE;
            end
            default: begin
              state_r <= IDLE;
              col_r   <= 9'd0;
              row_r   <= 9'd0;
              count_r <= 16'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_threshold.sv
// Directed bench for edge_threshold: three 4x4 instances with different
// adaptation settings share one stimulus stream.
module tb_edge_threshold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic       sof;
  logic [7:0] px;

  logic [7:0]  a_out, b_out, c_out;
  logic        a_flag, b_flag, c_flag;
  logic [7:0]  a_thr, b_thr, c_thr;
  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic        a_done, b_done, c_done;

  int checks   = 0;
  int failures = 0;

  edge_threshold #(.WIDTH(4), .HEIGHT(4), .BORDER(2), .THRESH_INIT(32),
                   .COUNT_HI(2000), .COUNT_LO(1)) dut_a (
    .Clk(clk), .Reset(reset), .en(en), .Sof(sof), .PixelIn(px),
    .PixelOut(a_out), .EdgeFlag(a_flag), .Threshold(a_thr),
    .EdgeCount(a_cnt), .FrameDone(a_done));

  edge_threshold #(.WIDTH(4), .HEIGHT(4), .BORDER(2), .THRESH_INIT(32),
                   .THRESH_MAX(33), .STEP(2), .COUNT_HI(3), .COUNT_LO(1)) dut_b (
    .Clk(clk), .Reset(reset), .en(en), .Sof(sof), .PixelIn(px),
    .PixelOut(b_out), .EdgeFlag(b_flag), .Threshold(b_thr),
    .EdgeCount(b_cnt), .FrameDone(b_done));

  edge_threshold #(.WIDTH(4), .HEIGHT(4), .BORDER(2), .THRESH_INIT(5),
                   .THRESH_MIN(4), .STEP(2), .COUNT_HI(2000), .COUNT_LO(1)) dut_c (
    .Clk(clk), .Reset(reset), .en(en), .Sof(sof), .PixelIn(px),
    .PixelOut(c_out), .EdgeFlag(c_flag), .Threshold(c_thr),
    .EdgeCount(c_cnt), .FrameDone(c_done));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic [7:0] p);
    @(negedge clk);
    en  = e;
    sof = s;
    px  = p;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] p);
    for (int i = 0; i < 16; i++) drive(1'b1, i == 0, p);
  endtask

  function automatic bit interior(input int i);
    return ((i % 4) >= 2) && ((i / 4) >= 2);
  endfunction

  logic [7:0] exp_px;
  logic [7:0] p;

  initial begin
    reset = 1'b1; en = 1'b0; sof = 1'b0; px = 8'h00;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b0;

    // Reset state
    check_eq("rst_thr_a", a_thr, 32'd32);
    check_eq("rst_thr_c", c_thr, 32'd5);
    check_eq("rst_cnt", a_cnt, 32'd0);
    check_eq("rst_out", a_out, 32'h00);
    check_eq("rst_flag", a_flag, 32'd0);
    check_eq("rst_done", a_done, 32'd0);

    // IDLE ignores pixels without Sof
    drive(1'b1, 1'b0, 8'hFF);
    check_eq("idle_out", a_out, 32'h00);

    // Latency, border and en gaps
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, 8'h40);
      exp_px = interior(i) ? 8'hFF : 8'h00;
      check_eq("t2_pix", a_out, 32'(exp_px));
      check_eq("t2_flag", a_flag, 32'(exp_px[7]));
      check_eq("t2_done", a_done, 32'(i == 15));
      drive(1'b0, 1'b0, 8'h00);
      check_eq("t2_hold", a_out, 32'(exp_px));
      check_eq("t2_done_gap", a_done, 32'd0);
    end
    check_eq("t2_cnt", a_cnt, 32'd4);
    check_eq("t2_thr_a", a_thr, 32'd32);
    check_eq("t2_thr_b_clamp", b_thr, 32'd33);
    check_eq("t2_thr_c", c_thr, 32'd5);

    drive(1'b1, 1'b0, 8'hFF);
    check_eq("post_frame_idle", a_out, 32'h00);

    // Threshold boundary: 0x20 hits, 0x1F misses at threshold 32
    for (int i = 0; i < 16; i++) begin
      p = interior(i) ? ((i % 2 == 0) ? 8'h20 : 8'h1F) : 8'hFF;
      drive(1'b1, i == 0, p);
      exp_px = (interior(i) && (i % 2 == 0)) ? 8'hFF : 8'h00;
      check_eq("t3_pix_a", a_out, 32'(exp_px));
      check_eq("t3_pix_b", b_out, 32'h00);
    end
    check_eq("t3_cnt_a", a_cnt, 32'd2);
    check_eq("t3_cnt_b", b_cnt, 32'd0);
    check_eq("t3_cnt_c", c_cnt, 32'd4);
    check_eq("t3_thr_a", a_thr, 32'd32);
    check_eq("t3_thr_b", b_thr, 32'd31);

    // Downward adaptation and lower clamp
    send_frame(8'h00);
    check_eq("t4_done", a_done, 32'd1);
    check_eq("t4_cnt_c", c_cnt, 32'd0);
    check_eq("t4_thr_c", c_thr, 32'd4);
    check_eq("t4_thr_a", a_thr, 32'd30);
    send_frame(8'h00);
    check_eq("t4_thr_c_clamp", c_thr, 32'd4);
    check_eq("t4_thr_a2", a_thr, 32'd28);

    // Sof abort at pixel 9
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i == 0, 8'h40);
      check_eq("t5_pre_done", a_done, 32'd0);
    end
    drive(1'b1, 1'b1, 8'h40);
    check_eq("t5_abort_done", a_done, 32'd0);
    check_eq("t5_abort_cnt", a_cnt, 32'd0);
    check_eq("t5_abort_out", a_out, 32'h00);
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'h40);
      check_eq("t5_done", a_done, 32'(i == 15));
    end
    check_eq("t5_cnt", a_cnt, 32'd4);
    check_eq("t5_thr", a_thr, 32'd28);

    // Sof on the last-pixel position wins; partial count discarded
    for (int i = 0; i < 15; i++) drive(1'b1, i == 0, 8'h40);
    drive(1'b1, 1'b1, 8'h40);
    check_eq("t5b_done", a_done, 32'd0);
    check_eq("t5b_out", a_out, 32'h00);
    check_eq("t5b_cnt_hold", a_cnt, 32'd4);
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 1'b0, (i == 15) ? 8'h00 : 8'h40);
      check_eq("t5b_run_done", a_done, 32'(i == 15));
    end
    check_eq("t5b_cnt", a_cnt, 32'd3);

    // Reset mid-frame, then pixels without Sof
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, 8'h40);
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    check_eq("t6_thr", a_thr, 32'd32);
    check_eq("t6_cnt", a_cnt, 32'd0);
    check_eq("t6_out", a_out, 32'h00);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'hFF);
      check_eq("t6_ign_out", a_out, 32'h00);
      check_eq("t6_ign_done", a_done, 32'd0);
    end
    send_frame(8'h40);
    check_eq("t6_frame_done", a_done, 32'd1);
    check_eq("t6_frame_cnt", a_cnt, 32'd4);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("t6_done_pulse", a_done, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
